regfile_sb: RTL

- Parametrised successor to the fixed 32x32, 2-read-port register file used by the single-cycle datapath.
- Generalised in data width, register count and number of read ports.
- Adds same-cycle write-to-read bypass and a per-register pending-write scoreboard, so the multi-cycle and pipelined datapaths can stall on long-latency writebacks (loads, multiply).
- Sits between decode/issue and writeback; exposes a flattened debug bus of all register values for the board display.

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_sb_sb_bits.sv | 46 ++++
 rtl/regfile_sb.sv | 81 ++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the parametrised register file and its scoreboard.
package regfile_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned NREG_DEF = 32;
  localparam int unsigned ZERO_REG = 0;

  // Low bit of element idx in a flattened bus of width-sized elements.
  function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/regfile_sb_sb_bits.sv
// Per-register pending-write bits plus a registered population count of them.
module sb_bits
  import regfile_pkg::*;
#(
  parameter int unsigned NREG = NREG_DEF,
  localparam int unsigned AW  = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            set,
  input  logic [AW-1:0]   set_addr,
  input  logic            clr,
  input  logic [AW-1:0]   clr_addr,
  output logic [NREG-1:0] busy,
  output logic [AW:0]     cnt
);

  logic [NREG-1:0] busy_nxt;
  logic [AW:0]     cnt_nxt;

  // Clear is applied before set so a same-cycle re-issue keeps the bit.
  always_comb begin
    busy_nxt = busy;
    if (clr) busy_nxt[clr_addr] = 1'b0;
    if (set) busy_nxt[set_addr] = 1'b1;
    busy_nxt[ZERO_REG] = 1'b0;
  end

  always_comb begin
    cnt_nxt = '0;
    for (int unsigned k = 0; k < NREG; k++) begin
      cnt_nxt = cnt_nxt + (AW+1)'(busy_nxt[k]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
      cnt  <= '0;
    end else begin
      busy <= busy_nxt;
      cnt  <= cnt_nxt;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Parametrised register file with write-to-read bypass, pending-write scoreboard and debug bus.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF,
  parameter int unsigned NREG = NREG_DEF,
  parameter int unsigned NRD  = 2,
  localparam int unsigned AW  = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*XLEN-1:0]  rd_data,
  output logic [NRD-1:0]       rd_busy,
  input  logic                 we,
  input  logic [AW-1:0]        wt_addr,
  input  logic [XLEN-1:0]      wt_data,
  input  logic                 iss_set,
  input  logic [AW-1:0]        iss_addr,
  output logic [AW:0]          busy_cnt,
  output logic [NREG*XLEN-1:0] dbg_regs
);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy;
  logic [AW-1:0]   ra;
  logic            hit_wr;
  logic            hit_iss;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < NREG; k++) begin
        regs[k] <= '0;
      end
    end else if (we && wt_addr != AW'(ZERO_REG)) begin
      regs[wt_addr] <= wt_data;
    end
  end

  sb_bits #(.NREG(NREG)) u_sb (
    .clk      (clk),
    .rst      (rst),
    .set      (iss_set),
    .set_addr (iss_addr),
    .clr      (we),
    .clr_addr (wt_addr),
    .busy     (busy),
    .cnt      (busy_cnt)
  );

  // A same-cycle writeback both supplies the data and releases the hazard,
  // unless the same register is re-issued in that cycle.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    ra      = '0;
    hit_wr  = 1'b0;
    hit_iss = 1'b0;
    for (int unsigned i = 0; i < NRD; i++) begin
      ra      = rd_addr[slice_lo(i, AW) +: AW];
      hit_wr  = we && (wt_addr == ra);
      hit_iss = iss_set && (iss_addr == ra);
      if (ra == AW'(ZERO_REG)) begin
        rd_data[slice_lo(i, XLEN) +: XLEN] = '0;
      end else if (hit_wr) begin
        rd_data[slice_lo(i, XLEN) +: XLEN] = wt_data;
      end else begin
        rd_data[slice_lo(i, XLEN) +: XLEN] = regs[ra];
      end
      rd_busy[i] = busy[ra] & ~(hit_wr & ~hit_iss);
    end
  end

  always_comb begin
    dbg_regs = '0;
    for (int unsigned k = 1; k < NREG; k++) begin
      dbg_regs[slice_lo(k, XLEN) +: XLEN] = regs[k];
    end
  end

endmodule
